// File: rtl/branch_ctrl_if.sv
// Branch control handshake bundle and shared types.
// Decode/comparator/fetch side drives master, branch_ctrl uses slave.
package branch_ctrl_pkg;
  typedef logic [2:0] comparator_func_code;

  localparam comparator_func_code FN_BEQ  = 3'd0;
  localparam comparator_func_code FN_BNE  = 3'd1;
  localparam comparator_func_code FN_BLT  = 3'd4;
  localparam comparator_func_code FN_BGE  = 3'd5;
  localparam comparator_func_code FN_BLTU = 3'd6;
  localparam comparator_func_code FN_BGEU = 3'd7;

  localparam logic [1:0] K_BR   = 2'b00;
  localparam logic [1:0] K_JAL  = 2'b01;
  localparam logic [1:0] K_JALR = 2'b10;
  localparam logic [1:0] K_ILL  = 2'b11;

  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL  = 2'b10;
endpackage

interface branch_ctrl_if;
  import branch_ctrl_pkg::*;

  logic                br_valid_ip;
  logic                br_ready_op;
  logic [1:0]          br_kind_ip;
  comparator_func_code br_func_ip;
  logic [31:0]         br_pc_ip;
  logic [31:0]         br_imm_ip;
  logic [31:0]         br_rs1_ip;
  logic [31:0]         br_rs2_ip;

  logic                comp_enable_op;
  comparator_func_code comp_func_op;
  logic [31:0]         comp_operand_a_op;
  logic [31:0]         comp_operand_b_op;
  logic                comp_result_ip;
  logic                comp_valid_ip;

  logic                redirect_valid_op;
  logic [31:0]         redirect_pc_op;
  logic                redirect_ack_ip;

  logic                flush_op;
  logic                link_valid_op;
  logic [31:0]         link_data_op;
  logic                fault_op;
  logic [1:0]          fault_cause_op;

  modport master (
    output br_valid_ip, br_kind_ip, br_func_ip,
    output br_pc_ip, br_imm_ip, br_rs1_ip, br_rs2_ip,
    output comp_result_ip, comp_valid_ip, redirect_ack_ip,
    input  br_ready_op, comp_enable_op, comp_func_op,
    input  comp_operand_a_op, comp_operand_b_op,
    input  redirect_valid_op, redirect_pc_op,
    input  flush_op, link_valid_op, link_data_op,
    input  fault_op, fault_cause_op
  );

  modport slave (
    input  br_valid_ip, br_kind_ip, br_func_ip,
    input  br_pc_ip, br_imm_ip, br_rs1_ip, br_rs2_ip,
    input  comp_result_ip, comp_valid_ip, redirect_ack_ip,
    output br_ready_op, comp_enable_op, comp_func_op,
    output comp_operand_a_op, comp_operand_b_op,
    output redirect_valid_op, redirect_pc_op,
    output flush_op, link_valid_op, link_data_op,
    output fault_op, fault_cause_op
  );
endinterface

// File: rtl/branch_ctrl.sv
// Control-transfer resolution: compare, redirect fetch, flush pipe.
// All outputs are registered; decisions are made on state transitions.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         reset,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REDIRECT,
    S_FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t              state_q;
  logic [1:0]          kind_q;
  logic [31:0]         tgt_q;
  logic [3:0]          cnt_q;
  logic                ready_q;
  logic                comp_en_q;
  comparator_func_code comp_func_q;
  logic [31:0]         comp_a_q;
  logic [31:0]         comp_b_q;
  logic                redir_v_q;
  logic [31:0]         redir_pc_q;
  logic                flush_q;
  logic                link_v_q;
  logic [31:0]         link_data_q;
  logic                fault_q;
  logic [1:0]          cause_q;

  logic [31:0]         tgt_d;
  logic                link_d;
  logic                func_bad;
  logic                illegal;
  logic                taken;

  // Target and link decision from the op being offered.
  always_comb begin
    tgt_d  = bus.br_pc_ip + bus.br_imm_ip;
    if (bus.br_kind_ip == K_JALR)
      tgt_d = (bus.br_rs1_ip + bus.br_imm_ip) & 32'hFFFF_FFFE;
    link_d = (bus.br_kind_ip == K_JAL || bus.br_kind_ip == K_JALR)
             && !tgt_d[1];
  end

  // Resolution of the captured op during EVAL.
  always_comb begin
    func_bad = (comp_func_q == 3'd2) || (comp_func_q == 3'd3);
    illegal  = (kind_q == K_ILL)
               || ((kind_q == K_BR)
                   && (!bus.comp_valid_ip || func_bad));
    taken    = (kind_q != K_BR) || bus.comp_result_ip;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      kind_q      <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      comp_en_q   <= 1'b0;
      comp_func_q <= '0;
      comp_a_q    <= '0;
      comp_b_q    <= '0;
      redir_v_q   <= 1'b0;
      redir_pc_q  <= '0;
      flush_q     <= 1'b0;
      link_v_q    <= 1'b0;
      link_data_q <= '0;
      fault_q     <= 1'b0;
      cause_q     <= '0;
    end else begin
      comp_en_q <= 1'b0;
      link_v_q  <= 1'b0;
      fault_q   <= 1'b0;
      cause_q   <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.br_valid_ip) begin
            state_q <= S_EVAL;
            ready_q <= 1'b0;
            kind_q  <= bus.br_kind_ip;
            tgt_q   <= tgt_d;
            if (bus.br_kind_ip == K_BR) begin
              comp_en_q   <= 1'b1;
              comp_func_q <= bus.br_func_ip;
              comp_a_q    <= bus.br_rs1_ip;
              comp_b_q    <= bus.br_rs2_ip;
            end
            if (link_d) begin
              link_v_q    <= 1'b1;
              link_data_q <= bus.br_pc_ip + 32'd4;
            end
          end
        end
        S_EVAL: begin
          if (illegal) begin
            fault_q <= 1'b1;
            cause_q <= C_ILLEGAL;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (!taken) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (tgt_q[1]) begin
            fault_q <= 1'b1;
            cause_q <= C_MISALIGN;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            redir_v_q  <= 1'b1;
            redir_pc_q <= tgt_q;
            state_q    <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (bus.redirect_ack_ip) begin
            redir_v_q <= 1'b0;
            flush_q   <= 1'b1;
            cnt_q     <= FLUSH_LAST;
            state_q   <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.br_ready_op       = ready_q;
  assign bus.comp_enable_op    = comp_en_q;
  assign bus.comp_func_op      = comp_func_q;
  assign bus.comp_operand_a_op = comp_a_q;
  assign bus.comp_operand_b_op = comp_b_q;
  assign bus.redirect_valid_op = redir_v_q;
  assign bus.redirect_pc_op    = redir_pc_q;
  assign bus.flush_op          = flush_q;
  assign bus.link_valid_op     = link_v_q;
  assign bus.link_data_op      = link_data_q;
  assign bus.fault_op          = fault_q;
  assign bus.fault_cause_op    = cause_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed cases then random ops
// checked against an outcome model of the branch rules.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int F = 2;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [2:0]  last_f = '0;

  branch_ctrl_if bus ();

  branch_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // At most one of the four pulse/level outputs may be high.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      vecs++;
      assert ($countones({bus.flush_op, bus.redirect_valid_op,
                          bus.link_valid_op, bus.fault_op}) <= 1)
      else begin
        errs++;
        $error("FAIL mutex: observed %b expected one-hot-or-zero",
               {bus.flush_op, bus.redirect_valid_op,
                bus.link_valid_op, bus.fault_op});
      end
    end
  end

  function automatic bit cmp_model(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_ready", bus.br_ready_op, 1);
    chk("rst_cen", bus.comp_enable_op, 0);
    chk("rst_cfunc", bus.comp_func_op, 0);
    chk("rst_ca", bus.comp_operand_a_op, 0);
    chk("rst_cb", bus.comp_operand_b_op, 0);
    chk("rst_rv", bus.redirect_valid_op, 0);
    chk("rst_rpc", bus.redirect_pc_op, 0);
    chk("rst_flush", bus.flush_op, 0);
    chk("rst_lv", bus.link_valid_op, 0);
    chk("rst_ld", bus.link_data_op, 0);
    chk("rst_fault", bus.fault_op, 0);
    chk("rst_cause", bus.fault_cause_op, 0);
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic do_op(input logic [1:0] k, input logic [2:0] f,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit cv, input int ackd,
                       input bit rst_mid);
    bit          cond, ill, tk, mis, lnk;
    logic [31:0] tgt;
    bit          res;
    cond = (k == 2'b00);
    res  = cmp_model(f, a, b);
    ill  = (k == 2'b11) ||
           (cond && (!cv || f == 3'd2 || f == 3'd3));
    tk   = !cond || res;
    tgt  = (k == 2'b10) ? ((a + imm) & ~32'd1) : pc + imm;
    mis  = tgt[1];
    lnk  = (k == 2'b01 || k == 2'b10) && !mis;

    chk("idle_ready", bus.br_ready_op, 1);
    bus.br_valid_ip    = 1'b1;
    bus.br_kind_ip     = k;
    bus.br_func_ip     = f;
    bus.br_pc_ip       = pc;
    bus.br_imm_ip      = imm;
    bus.br_rs1_ip      = a;
    bus.br_rs2_ip      = b;
    bus.comp_valid_ip  = cv;
    bus.comp_result_ip = cv ? res : 1'($urandom);
    @(negedge clk);
    bus.br_valid_ip     = 1'b0;
    bus.redirect_ack_ip = 1'($urandom);
    chk("eval_ready", bus.br_ready_op, 0);
    chk("eval_cen", bus.comp_enable_op, cond);
    if (cond) begin
      last_a = a;
      last_b = b;
      last_f = f;
    end
    chk("eval_cfunc", bus.comp_func_op, last_f);
    chk("eval_ca", bus.comp_operand_a_op, last_a);
    chk("eval_cb", bus.comp_operand_b_op, last_b);
    chk("eval_link", bus.link_valid_op, lnk);
    if (lnk) chk("eval_ldata", bus.link_data_op, pc + 32'd4);
    chk("eval_fault", bus.fault_op, 0);
    chk("eval_rv", bus.redirect_valid_op, 0);
    @(negedge clk);
    bus.redirect_ack_ip = 1'b0;
    chk("n2_link", bus.link_valid_op, 0);
    chk("n2_cen", bus.comp_enable_op, 0);
    if (ill || (tk && mis)) begin
      chk("fault", bus.fault_op, 1);
      chk("cause", bus.fault_cause_op, ill ? 2'b10 : 2'b01);
      chk("flt_ready", bus.br_ready_op, 1);
      chk("flt_rv", bus.redirect_valid_op, 0);
      return;
    end
    chk("n2_fault", bus.fault_op, 0);
    if (!tk) begin
      chk("nt_ready", bus.br_ready_op, 1);
      chk("nt_rv", bus.redirect_valid_op, 0);
      return;
    end
    for (int i = 0; i < ackd; i++) begin
      chk("rd_valid", bus.redirect_valid_op, 1);
      chk("rd_pc", bus.redirect_pc_op, tgt);
      chk("rd_ready", bus.br_ready_op, 0);
      if (rst_mid && i == 1) begin
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        last_a = '0;
        last_b = '0;
        last_f = '0;
        @(negedge clk);
        chk("post_rst_rv", bus.redirect_valid_op, 0);
        chk("post_rst_flush", bus.flush_op, 0);
        return;
      end
      @(negedge clk);
    end
    chk("ack_valid", bus.redirect_valid_op, 1);
    chk("ack_pc", bus.redirect_pc_op, tgt);
    bus.redirect_ack_ip = 1'b1;
    @(negedge clk);
    bus.redirect_ack_ip = 1'b0;
    for (int i = 0; i < F; i++) begin
      chk("flush", bus.flush_op, 1);
      chk("fl_rv", bus.redirect_valid_op, 0);
      chk("fl_ready", bus.br_ready_op, 0);
      @(negedge clk);
    end
    chk("fl_done", bus.flush_op, 0);
  endtask

  initial begin
    logic [1:0]  k;
    logic [31:0] a, b;
    reset               = 1'b0;
    bus.br_valid_ip     = 1'b0;
    bus.br_kind_ip      = '0;
    bus.br_func_ip      = '0;
    bus.br_pc_ip        = '0;
    bus.br_imm_ip       = '0;
    bus.br_rs1_ip       = '0;
    bus.br_rs2_ip       = '0;
    bus.comp_result_ip  = 1'b0;
    bus.comp_valid_ip   = 1'b0;
    bus.redirect_ack_ip = 1'b0;
    #12 chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.br_ready_op, 1);

    // BEQ taken, ack in first redirect cycle
    do_op(2'b00, FN_BEQ, 32'h100, 32'h20, 5, 5, 1, 0, 0);
    // BLTU taken, BLT not taken on same operands
    do_op(2'b00, FN_BLTU, 32'h200, 32'h40, 1, 32'hFFFF_FFFF,
          1, 0, 0);
    do_op(2'b00, FN_BLT, 32'h200, 32'h40, 1, 32'hFFFF_FFFF,
          1, 0, 0);
    // JALR to 0x1002: misaligned, no link
    do_op(2'b10, FN_BEQ, 32'h300, 32'h0, 32'h1003, 0, 1, 0, 0);
    // JAL wrapping past 2^32
    do_op(2'b01, FN_BEQ, 32'hFFFF_FFFC, 32'h8, 0, 0, 1, 1, 0);
    // ack withheld, reset in 2nd redirect cycle
    do_op(2'b00, FN_BNE, 32'h400, 32'h10, 1, 2, 1, 3, 1);
    // illegal kind, comparator invalid, illegal func
    do_op(2'b11, FN_BEQ, 32'h500, 32'h8, 0, 0, 1, 0, 0);
    do_op(2'b00, FN_BEQ, 32'h500, 32'h8, 7, 7, 0, 0, 0);
    do_op(2'b00, 3'd3, 32'h500, 32'h8, 7, 7, 1, 0, 0);
    // ack withheld 3 cycles without reset
    do_op(2'b01, FN_BEQ, 32'h600, 32'h100, 0, 0, 1, 3, 0);

    for (int n = 0; n < 300; n++) begin
      k = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      do_op(k, 3'($urandom),
            $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 1) == 1) ?
              ($urandom & 32'hFFFF_FFFC) : $urandom,
            a, b, $urandom_range(0, 7) != 0,
            $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
